traffic_light_ctrl: RTL and testbench

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/traffic_pkg.sv | 50 +++++
 rtl/traffic_light_ctrl.sv | 108 ++++++++++
 tb/tb_traffic_light_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// ============================================================================
// Module  : traffic_pkg
// Brief   : Shared state, lamp and direction encodings for the traffic light
//           controller, plus lamp decode helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    typedef enum logic [2:0] {
        INIT_RED  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        RED_1     = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        RED_2     = 3'd6,
        PED_WALK  = 3'd7
    } state_t;

    typedef enum logic {
        NS = 1'b0,
        EW = 1'b1
    } dir_t;

    // Lamp bus order is {R,Y,G}
    localparam logic [2:0] c_lamp_red = 3'b100;
    localparam logic [2:0] c_lamp_yel = 3'b010;
    localparam logic [2:0] c_lamp_grn = 3'b001;

    function automatic logic [2:0] ns_lamp(input state_t s);
        case (s)
            NS_GREEN:  return c_lamp_grn;
            NS_YELLOW: return c_lamp_yel;
            default:   return c_lamp_red;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input state_t s);
        case (s)
            EW_GREEN:  return c_lamp_grn;
            EW_YELLOW: return c_lamp_yel;
            default:   return c_lamp_red;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
// ============================================================================
// Module  : traffic_light_ctrl
// Brief   : Two-road traffic light sequencer with pedestrian walk phase, paced
//           by an external seconds timer via delay/timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned T_GREEN  = 10,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_ALLRED = 1,
    parameter int unsigned T_WALK   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        timeout,
    input  logic        ped_req,
    output logic [31:0] delay,
    output logic [2:0]  ns_light,
    output logic [2:0]  ew_light,
    output logic        ped_walk
);

    // A zero duration would leave the timer expired forever.
    if (T_GREEN < 1 || T_YELLOW < 1 || T_ALLRED < 1 || T_WALK < 1) begin : g_bad_duration
        $error("traffic_light_ctrl: all durations must be >= 1");
    end

    function automatic logic [31:0] duration(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   return 32'(T_GREEN);
            NS_YELLOW, EW_YELLOW: return 32'(T_YELLOW);
            PED_WALK:             return 32'(T_WALK);
            default:              return 32'(T_ALLRED);
        endcase
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    dir_t        r_next_dir;
    dir_t        w_next_dir_nxt;
    logic        r_ped_pending;
    logic        w_ped_pending_nxt;
    logic [31:0] r_delay;
    logic [2:0]  r_ns_light;
    logic [2:0]  r_ew_light;
    logic        r_ped_walk;
    logic        w_enter_walk;

    always_comb begin
        w_state_nxt    = r_state;
        w_next_dir_nxt = r_next_dir;
        if (timeout) begin
            case (r_state)
                INIT_RED:  w_state_nxt = NS_GREEN;
                NS_GREEN:  w_state_nxt = NS_YELLOW;
                NS_YELLOW: w_state_nxt = RED_1;
                RED_1: begin
                    w_state_nxt    = r_ped_pending ? PED_WALK : EW_GREEN;
                    w_next_dir_nxt = EW;
                end
                EW_GREEN:  w_state_nxt = EW_YELLOW;
                EW_YELLOW: w_state_nxt = RED_2;
                RED_2: begin
                    w_state_nxt    = r_ped_pending ? PED_WALK : NS_GREEN;
                    w_next_dir_nxt = NS;
                end
                PED_WALK:  w_state_nxt = (r_next_dir == EW) ? EW_GREEN : NS_GREEN;
                default:   w_state_nxt = INIT_RED;
            endcase
        end

        // A request arriving on the entry edge is served by the walk now starting.
        w_enter_walk      = (w_state_nxt == PED_WALK) && (r_state != PED_WALK);
        w_ped_pending_nxt = w_enter_walk ? 1'b0 : (r_ped_pending | ped_req);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= INIT_RED;
            r_next_dir    <= NS;
            r_ped_pending <= 1'b0;
            r_delay       <= 32'(T_ALLRED);
            r_ns_light    <= c_lamp_red;
            r_ew_light    <= c_lamp_red;
            r_ped_walk    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_next_dir    <= w_next_dir_nxt;
            r_ped_pending <= w_ped_pending_nxt;
            r_delay       <= duration(w_state_nxt);
            r_ns_light    <= ns_lamp(w_state_nxt);
            r_ew_light    <= ew_lamp(w_state_nxt);
            r_ped_walk    <= (w_state_nxt == PED_WALK);
        end
    end

    assign delay    = r_delay;
    assign ns_light = r_ns_light;
    assign ew_light = r_ew_light;
    assign ped_walk = r_ped_walk;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
// ============================================================================
// Module  : tb_traffic_light_ctrl
// Brief   : Scoreboard bench for traffic_light_ctrl with an optional
//           cycle-scaled seconds timer for closed-loop operation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_light_ctrl;
    import traffic_pkg::*;

    localparam int P = 4;  // clock cycles per simulated second

    // Expected {ns, ew, walk, delay} tuples, hand-derived
    localparam logic [38:0] E_RST  = {3'b100, 3'b100, 1'b0, 32'd1};
    localparam logic [38:0] E_NSG  = {3'b001, 3'b100, 1'b0, 32'd10};
    localparam logic [38:0] E_NSY  = {3'b010, 3'b100, 1'b0, 32'd3};
    localparam logic [38:0] E_R1   = {3'b100, 3'b100, 1'b0, 32'd1};
    localparam logic [38:0] E_EWG  = {3'b100, 3'b001, 1'b0, 32'd10};
    localparam logic [38:0] E_EWY  = {3'b100, 3'b010, 1'b0, 32'd3};
    localparam logic [38:0] E_R2   = {3'b100, 3'b100, 1'b0, 32'd1};
    localparam logic [38:0] E_WALK = {3'b100, 3'b100, 1'b1, 32'd5};

    logic        clk = 1'b0;
    logic        reset;
    logic        tb_to;
    logic        integ;
    logic        tmr_to;
    logic        timeout;
    logic        ped_req;
    logic [31:0] delay;
    logic [2:0]  ns_light;
    logic [2:0]  ew_light;
    logic        ped_walk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int gap_sel  = 0;

    string       q_tag[$];
    logic [38:0] q_exp[$];

    traffic_light_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .timeout  (timeout),
        .ped_req  (ped_req),
        .delay    (delay),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .ped_walk (ped_walk)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Seconds timer: elapsed seconds counted in units of P cycles
    logic [31:0] t_elapsed;
    int          t_pc;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t_elapsed <= 32'd0;
            t_pc      <= 0;
        end else if (!integ) begin
            t_elapsed <= 32'd0;
            t_pc      <= 0;
        end else if (tmr_to) begin
            t_elapsed <= 32'd0;
            t_pc      <= 1;
        end else if (t_pc == P - 1) begin
            t_elapsed <= t_elapsed + 32'd1;
            t_pc      <= 0;
        end else begin
            t_pc <= t_pc + 1;
        end
    end
    assign tmr_to  = integ && (t_elapsed == delay);
    assign timeout = integ ? tmr_to : tb_to;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input string tag, input logic [38:0] e);
        q_tag.push_back(tag);
        q_exp.push_back(e);
    endtask

    task automatic pulse(input string tag, input logic [38:0] e, input bit with_ped);
        push(tag, e);
        @(posedge clk); #1;
        tb_to = 1'b1;
        if (with_ped) ped_req = 1'b1;
        @(posedge clk); #1;
        tb_to   = 1'b0;
        ped_req = 1'b0;
        repeat (gap_sel % 3) @(posedge clk);
        gap_sel++;
    endtask

    task automatic ped_pulse();
        @(posedge clk); #1;
        ped_req = 1'b1;
        @(posedge clk); #1;
        ped_req = 1'b0;
    endtask

    // Monitor: every change of the observable tuple consumes one expectation
    initial begin
        logic [38:0] prev;
        logic [38:0] cur;
        prev = 'x;
        forever begin
            @(negedge clk);
            cur = {ns_light, ew_light, ped_walk, delay};
            if (cur !== prev) begin
                prev = cur;
                if (q_exp.size() == 0) begin
                    chk("unexpected_change", 64'(cur), 64'(39'h0));
                end else begin
                    chk(q_tag.pop_front(), 64'(cur), 64'(q_exp.pop_front()));
                end
            end
        end
    end

    // Lamp safety on every cycle
    always @(negedge clk) begin
        logic ns_act;
        logic ew_act;
        logic safe;
        ns_act = (ns_light == 3'b010) || (ns_light == 3'b001);
        ew_act = (ew_light == 3'b010) || (ew_light == 3'b001);
        safe   = $onehot(ns_light) && $onehot(ew_light) && !(ns_act && ew_act) &&
                 !(ped_walk && (ns_light != 3'b100 || ew_light != 3'b100));
        chk("lamp_safety", 64'(safe), 64'd1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dseq[6];
        int last;
        int g;
        dseq = '{10, 3, 1, 10, 3, 1};

        reset = 1'b1; tb_to = 1'b0; ped_req = 1'b0; integ = 1'b0;
        push("reset_state", E_RST);
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // First timeout and a full cycle without pedestrians
        pulse("init_to_nsg", E_NSG, 0);
        pulse("cyc_nsy",  E_NSY, 0);
        pulse("cyc_r1",   E_R1,  0);
        pulse("cyc_ewg",  E_EWG, 0);
        pulse("cyc_ewy",  E_EWY, 0);
        pulse("cyc_r2",   E_R2,  0);
        pulse("cyc_nsg",  E_NSG, 0);

        // One-cycle request during NS green
        ped_pulse();
        pulse("ped_nsy",  E_NSY,  0);
        pulse("ped_r1",   E_R1,   0);
        pulse("ped_walk", E_WALK, 0);
        chk("ped_pending_clr", 64'(dut.r_ped_pending), 64'd0);
        pulse("ped_ewg",  E_EWG, 0);
        pulse("ped_ewy",  E_EWY, 0);
        pulse("ped_r2",   E_R2,  0);
        pulse("ped_nsg",  E_NSG, 0);

        // Request coincident with the walk-entry edge is absorbed
        ped_pulse();
        pulse("co_nsy",  E_NSY,  0);
        pulse("co_r1",   E_R1,   0);
        pulse("co_walk", E_WALK, 1);
        chk("co_pending_clr", 64'(dut.r_ped_pending), 64'd0);
        pulse("co_ewg",  E_EWG, 0);
        pulse("co_ewy",  E_EWY, 0);
        pulse("co_r2",   E_R2,  0);
        pulse("co_nsg_no_walk", E_NSG, 0);

        // Walk from RED_2 returns to NS; request during walk served at RED_1
        pulse("lw_nsy", E_NSY, 0);
        pulse("lw_r1",  E_R1,  0);
        pulse("lw_ewg", E_EWG, 0);
        ped_pulse();
        pulse("lw_ewy",   E_EWY,  0);
        pulse("lw_r2",    E_R2,   0);
        pulse("lw_walk1", E_WALK, 0);
        ped_pulse();
        pulse("lw_nsg",   E_NSG,  0);
        pulse("lw_nsy2",  E_NSY,  0);
        pulse("lw_r1b",   E_R1,   0);
        pulse("lw_walk2", E_WALK, 0);
        pulse("lw_ewg2",  E_EWG,  0);

        // Asynchronous reset during EW yellow
        pulse("ar_ewy", E_EWY, 0);
        push("ar_reset", E_RST);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("ar_ns_async", 64'(ns_light), 64'(3'b100));
        chk("ar_ew_async", 64'(ew_light), 64'(3'b100));
        chk("ar_state", 64'(dut.r_state), 64'(INIT_RED));
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        pulse("ar_nsg", E_NSG, 0);

        // Closed loop with the seconds timer over three full cycles
        push("it_reset", E_RST);
        @(posedge clk); #1;
        reset = 1'b1;
        integ = 1'b1;
        push("it_nsg0", E_NSG);
        for (int c = 0; c < 3; c++) begin
            push("it_nsy", E_NSY);
            push("it_r1",  E_R1);
            push("it_ewg", E_EWG);
            push("it_ewy", E_EWY);
            push("it_r2",  E_R2);
            push("it_nsg", E_NSG);
        end
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        last = 0;
        for (int k = 0; k < 19; k++) begin
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!timeout && g < 200);
            if (!timeout) begin
                chk("timer_wait", 64'd0, 64'd1);
                break;
            end
            if (k > 0) chk("timeout_spacing", 64'(cyc - last), 64'(P * dseq[(k - 1) % 6]));
            last = cyc;
        end
        @(posedge clk); #1;
        integ = 1'b0;

        repeat (5) @(posedge clk);
        chk("queue_empty", 64'(q_exp.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
